// File: rtl/operand_fwd_unit.sv
// EX-stage operand forwarding with per-operand hold registers and a
// load-use stall controller driving the IF/ID freeze and ID/EX bubble.
module operand_fwd_unit #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned NOPS       = 2,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned R0_ZERO    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NOPS*AW-1:0]   ex_src,
  input  logic [NOPS*DW-1:0]   ex_rf_val,
  input  logic                 ex_advance,
  input  logic                 idex_wr,
  input  logic                 idex_load,
  input  logic [AW-1:0]        idex_rd,
  input  logic [NOPS*AW-1:0]   id_src,
  input  logic [NOPS-1:0]      id_src_used,
  input  logic                 exm_wr,
  input  logic                 exm_load,
  input  logic [AW-1:0]        exm_rd,
  input  logic [DW-1:0]        exm_val,
  input  logic                 mwb_wr,
  input  logic [AW-1:0]        mwb_rd,
  input  logic [DW-1:0]        mwb_val,
  output logic [NOPS*DW-1:0]   op_out,
  output logic [NOPS*2-1:0]    fwd_sel,
  output logic                 stall_id
);

  localparam int unsigned CNT_INIT = (LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0;

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NOPS-1:0]   hold_valid;
  logic [DW-1:0]     hold_data [NOPS];
  logic [NOPS-1:0]   exm_hit, mwb_hit;
  logic [DW-1:0]     live_val  [NOPS];
  logic              exm_rd_ok, mwb_rd_ok, idex_rd_ok;
  logic              detect;

  assign exm_rd_ok  = !((R0_ZERO != 0) && (exm_rd == '0));
  assign mwb_rd_ok  = !((R0_ZERO != 0) && (mwb_rd == '0));
  assign idex_rd_ok = !((R0_ZERO != 0) && (idex_rd == '0));

  // A load in EX/MEM has no data yet, so it never forwards from there.
  always_comb begin
    exm_hit = '0;
    mwb_hit = '0;
    op_out  = '0;
    fwd_sel = '0;
    for (int unsigned i = 0; i < NOPS; i++) begin
      live_val[i] = '0;
      exm_hit[i]  = exm_wr && !exm_load && exm_rd_ok && (exm_rd == ex_src[i*AW +: AW]);
      mwb_hit[i]  = mwb_wr && mwb_rd_ok && (mwb_rd == ex_src[i*AW +: AW]);
      if (exm_hit[i]) begin
        live_val[i]        = exm_val;
        op_out[i*DW +: DW] = exm_val;
        fwd_sel[i*2 +: 2]  = 2'b10;
      end else if (mwb_hit[i]) begin
        live_val[i]        = mwb_val;
        op_out[i*DW +: DW] = mwb_val;
        fwd_sel[i*2 +: 2]  = 2'b01;
      end else if (hold_valid[i]) begin
        op_out[i*DW +: DW] = hold_data[i];
        fwd_sel[i*2 +: 2]  = 2'b11;
      end else begin
        op_out[i*DW +: DW] = ex_rf_val[i*DW +: DW];
        fwd_sel[i*2 +: 2]  = 2'b00;
      end
    end
  end

  // Advancing EX always clears the hold, even if a live hit is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      for (int unsigned i = 0; i < NOPS; i++) hold_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NOPS; i++) begin
        if (ex_advance) begin
          hold_valid[i] <= 1'b0;
        end else if (exm_hit[i] || mwb_hit[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= live_val[i];
        end
      end
    end
  end

  always_comb begin
    detect = 1'b0;
    for (int unsigned i = 0; i < NOPS; i++) begin
      if (id_src_used[i] && (id_src[i*AW +: AW] == idex_rd)) detect = 1'b1;
    end
    detect = detect && idex_load && idex_wr && idex_rd_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Remaining stall cycles only count down while EX is actually advancing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_id = detect;
    unique case (state_q)
      RUN: begin
        if (detect && ex_advance && (LOAD_STALL > 1)) begin
          state_d = STALL;
          cnt_d   = CNT_INIT[1:0];
        end
      end
      STALL: begin
        stall_id = 1'b1;
        if (ex_advance) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed scoreboard bench for operand_fwd_unit with LOAD_STALL=1 and =3
// instances sharing one stimulus stream.
module tb_operand_fwd_unit;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NOPS = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NOPS*AW-1:0]   ex_src, id_src;
  logic [NOPS*DW-1:0]   ex_rf_val;
  logic                 ex_advance, idex_wr, idex_load;
  logic [AW-1:0]        idex_rd, exm_rd, mwb_rd;
  logic [NOPS-1:0]      id_src_used;
  logic                 exm_wr, exm_load, mwb_wr;
  logic [DW-1:0]        exm_val, mwb_val;
  logic [NOPS*DW-1:0]   op_out_a, op_out_b;
  logic [NOPS*2-1:0]    fwd_sel_a, fwd_sel_b;
  logic                 stall_a, stall_b;

  typedef struct {
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  operand_fwd_unit #(.DW(DW), .AW(AW), .NOPS(NOPS), .LOAD_STALL(1), .R0_ZERO(1)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .ex_rf_val(ex_rf_val),
    .ex_advance(ex_advance), .idex_wr(idex_wr), .idex_load(idex_load),
    .idex_rd(idex_rd), .id_src(id_src), .id_src_used(id_src_used),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_val(exm_val),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
    .op_out(op_out_a), .fwd_sel(fwd_sel_a), .stall_id(stall_a)
  );

  operand_fwd_unit #(.DW(DW), .AW(AW), .NOPS(NOPS), .LOAD_STALL(3), .R0_ZERO(1)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .ex_rf_val(ex_rf_val),
    .ex_advance(ex_advance), .idex_wr(idex_wr), .idex_load(idex_load),
    .idex_rd(idex_rd), .id_src(id_src), .id_src_used(id_src_used),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_val(exm_val),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
    .op_out(op_out_b), .fwd_sel(fwd_sel_b), .stall_id(stall_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string sig_name(input int s);
    case (s)
      0: return "op0_a";
      1: return "op1_a";
      2: return "sel0_a";
      3: return "sel1_a";
      4: return "stall_ls1";
      5: return "stall_ls3";
      6: return "op_out_ls3";
      default: return "fwd_sel_ls3";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int s);
    case (s)
      0: return {16'h0, op_out_a[15:0]};
      1: return {16'h0, op_out_a[31:16]};
      2: return {30'h0, fwd_sel_a[1:0]};
      3: return {30'h0, fwd_sel_a[3:2]};
      4: return {31'h0, stall_a};
      5: return {31'h0, stall_b};
      6: return op_out_b;
      default: return {28'h0, fwd_sel_b};
    endcase
  endfunction

  task automatic push(input int s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic exp_ops(input logic [15:0] o0, input logic [15:0] o1,
                         input logic [1:0] s0, input logic [1:0] s1);
    push(0, {16'h0, o0});
    push(1, {16'h0, o1});
    push(2, {30'h0, s0});
    push(3, {30'h0, s1});
  endtask

  task automatic exp_st(input logic a, input logic b);
    push(4, {31'h0, a});
    push(5, {31'h0, b});
  endtask

  task automatic settle();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(sig_name(e.sig), actual(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_src      = {4'd9, 4'd8};
    ex_rf_val   = {16'hA1A1, 16'hA0A0};
    ex_advance  = 1'b1;
    idex_wr     = 1'b0;
    idex_load   = 1'b0;
    idex_rd     = 4'd15;
    id_src      = {4'd14, 4'd13};
    id_src_used = '0;
    exm_wr      = 1'b0;
    exm_load    = 1'b0;
    exm_rd      = 4'd0;
    exm_val     = 16'h0;
    mwb_wr      = 1'b0;
    mwb_rd      = 4'd0;
    mwb_val     = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #3;
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    exp_st(1'b0, 1'b0);
    settle();
    step();
    rst_n = 1'b1;

    // Back-to-back ALU dependency, EX/MEM beats MEM/WB
    step();
    ex_src = {4'd9, 4'd3};
    exm_wr = 1'b1; exm_rd = 4'd3; exm_val = 16'h1234;
    exp_ops(16'h1234, 16'hA1A1, 2'b10, 2'b00);
    settle();
    step();
    mwb_wr = 1'b1; mwb_rd = 4'd3; mwb_val = 16'h5555;
    exp_ops(16'h1234, 16'hA1A1, 2'b10, 2'b00);
    settle();
    // Load in EX/MEM is not forwarded; MEM/WB takes over
    step();
    exm_load = 1'b1;
    exp_ops(16'h5555, 16'hA1A1, 2'b01, 2'b00);
    settle();
    step();
    mwb_wr = 1'b0;
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    settle();

    // Two-ahead dependency and r0 suppression
    step();
    idle();
    ex_src = {4'd5, 4'd8};
    mwb_wr = 1'b1; mwb_rd = 4'd5; mwb_val = 16'hBEEF;
    exp_ops(16'hA0A0, 16'hBEEF, 2'b00, 2'b01);
    settle();
    step();
    ex_src = {4'd0, 4'd8}; mwb_rd = 4'd0;
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    settle();

    // EX stall across retire
    step();
    ex_src = {4'd5, 4'd8}; mwb_rd = 4'd5; ex_advance = 1'b0;
    exp_ops(16'hA0A0, 16'hBEEF, 2'b00, 2'b01);
    settle();
    step();
    mwb_wr = 1'b0; ex_rf_val = {16'h0B0B, 16'hA0A0};
    exp_ops(16'hA0A0, 16'hBEEF, 2'b00, 2'b11);
    settle();
    step();
    ex_advance = 1'b1;
    exp_ops(16'hA0A0, 16'hBEEF, 2'b00, 2'b11);
    settle();
    step();
    exp_ops(16'hA0A0, 16'h0B0B, 2'b00, 2'b00);
    settle();

    // Load-use: LS1 stalls 1 cycle, LS3 stalls 4 with one frozen EX cycle
    step();
    idle();
    idex_load = 1'b1; idex_wr = 1'b1; idex_rd = 4'd2;
    id_src = {4'd14, 4'd2}; id_src_used = 2'b01;
    exp_st(1'b1, 1'b1);
    settle();
    step();
    idex_load = 1'b0; idex_wr = 1'b0;
    ex_src = {4'd9, 4'd2}; mwb_wr = 1'b1; mwb_rd = 4'd2; mwb_val = 16'h7777;
    ex_advance = 1'b0;
    exp_ops(16'h7777, 16'hA1A1, 2'b01, 2'b00);
    exp_st(1'b0, 1'b1);
    settle();
    step();
    mwb_wr = 1'b0; ex_advance = 1'b1;
    exp_ops(16'h7777, 16'hA1A1, 2'b11, 2'b00);
    exp_st(1'b0, 1'b1);
    push(6, {16'hA1A1, 16'h7777});
    push(7, 32'h3);
    settle();
    step();
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    exp_st(1'b0, 1'b1);
    settle();
    step();
    exp_st(1'b0, 1'b0);
    settle();

    // Reset mid-STALL and mid-hold
    step();
    idle();
    idex_load = 1'b1; idex_wr = 1'b1; idex_rd = 4'd2;
    id_src = {4'd14, 4'd2}; id_src_used = 2'b01;
    exp_st(1'b1, 1'b1);
    settle();
    step();
    idex_load = 1'b0; idex_wr = 1'b0; ex_advance = 1'b0;
    ex_src = {4'd5, 4'd8}; mwb_wr = 1'b1; mwb_rd = 4'd5; mwb_val = 16'hCAFE;
    exp_ops(16'hA0A0, 16'hCAFE, 2'b00, 2'b01);
    exp_st(1'b0, 1'b1);
    settle();
    step();
    mwb_wr = 1'b0;
    exp_ops(16'hA0A0, 16'hCAFE, 2'b00, 2'b11);
    exp_st(1'b0, 1'b1);
    settle();
    #1;
    rst_n = 1'b0;
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    exp_st(1'b0, 1'b0);
    settle();
    push(7, 32'h0);
    settle();
    rst_n = 1'b1;
    step();
    exp_ops(16'hA0A0, 16'hA1A1, 2'b00, 2'b00);
    exp_st(1'b0, 1'b0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fwd_unit.md
# operand_fwd_unit

Parametrised EX-stage operand forwarding and load-use hazard unit for the 16-bit pipeline. It replaces the per-operand forwarding muxes with a single block for NOPS operands. Each operand has a hold register, so a forwarded value survives an EX-stage stall after its producer has retired. A load-use stall controller drives the IF/ID freeze and the ID/EX bubble. The block sits between the ID/EX register and the ALU input.

## Interface
- DW, 16, data width
- AW, 4, register-address width
- NOPS, 2, number of forwarded operands (channel i occupies bits [i*DW +: DW] / [i*AW +: AW])
- LOAD_STALL, 1, ID stall cycles per load-use hazard (1..3)
- R0_ZERO, 1, when 1, writes to register 0 are never forwarded or hazard-checked

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_src  in  NOPS*AW  source register of each operand of the instruction in EX
- ex_rf_val  in  NOPS*DW  register-file values latched in ID/EX
- ex_advance  in  1  EX instruction moves to MEM at this edge (0 = EX stalled)
- idex_wr, idex_load  in  1 each  EX instruction writes a register / is a load
- idex_rd  in  AW  EX instruction destination
- id_src  in  NOPS*AW  source registers of the instruction in ID
- id_src_used  in  NOPS  per-operand "ID actually reads this source"
- exm_wr, exm_load  in  1 each  EX/MEM write enable / is a load
- exm_rd  in  AW; exm_val  in  DW  EX/MEM destination and ALU result
- mwb_wr  in  1; mwb_rd  in  AW; mwb_val  in  DW  MEM/WB write-back
- op_out  out  NOPS*DW  forwarded operands to the ALU
- fwd_sel  out  NOPS*2  per operand: 00 RF, 10 EX/MEM, 01 MEM/WB, 11 hold
- stall_id  out  1  freeze PC and IF/ID; insert bubble into ID/EX

## Operation
- Hit definitions per operand i:
  - EX/MEM hit = exm_wr & exm_rd==ex_src[i] & !exm_load & !(R0_ZERO & exm_rd==0).
  - MEM/WB hit = mwb_wr & mwb_rd==ex_src[i] & !(R0_ZERO & mwb_rd==0).
- Selection priority: EX/MEM hit (10) > MEM/WB hit (01) > hold_valid[i] (11) > ex_rf_val (00). op_out[i] is the selected value.
- Hold register per operand (hold_valid, hold_data), captured at each edge:
  - If ex_advance=1: hold_valid <= 0.
  - Else if sel is 10 or 01: hold_valid <= 1 and hold_data <= selected value.
  - Else: hold is unchanged.
- A live hit always overrides hold. A live producer is never older than the held one, so the held value is never stale.
- Load-use detection: detect = idex_load & idex_wr & !(R0_ZERO & idex_rd==0) & OR over i of (id_src_used[i] & id_src[i]==idex_rd).
- Stall controller states:
  - RUN: stall_id = detect. If detect & ex_advance & LOAD_STALL>1, go to STALL and set cnt <= LOAD_STALL-2.
  - STALL: stall_id=1. If cnt==0, go to RUN; otherwise cnt <= cnt-1. cnt counts only on cycles with ex_advance=1.
- With LOAD_STALL=1 the FSM stays in RUN. The bubble entering EX removes detect on the next cycle.
- An EX/MEM hit with exm_load=1 is suppressed, because the loaded value is not yet valid. The stall guarantees the load is in MEM/WB before use.

## Timing
- op_out, fwd_sel and stall_id are combinational from the inputs and the current state. There is no added latency.
- Hold registers, FSM state and cnt update on the rising clk edge.
- Reset (rst_n low, asynchronous) sets:
  - hold_valid=0 and hold_data=0 for every operand;
  - state=RUN and cnt=0.
- During reset, op_out and fwd_sel follow the live sources only, and stall_id equals detect.
- Reset asserted in STALL returns the FSM to RUN immediately. stall_id drops in the same cycle unless detect is true.
- If ex_advance=0 while in STALL, cnt holds and stall_id stays 1.
- When hold capture and ex_advance=1 occur in the same cycle, the clear wins.

## Test plan
- Back-to-back ALU dependency: exm_wr=1, exm_rd=3, exm_val=0x1234, ex_src[0]=3 -> fwd_sel[0]=10, op_out[0]=0x1234. Add mwb_rd=3, mwb_val=0x5555 -> EX/MEM still wins.
- Two-ahead dependency: only mwb_rd=5, mwb_val=0xBEEF matches ex_src[1]=5 -> fwd_sel[1]=01, op_out[1]=0xBEEF. The same hit with mwb_rd=0 and R0_ZERO=1 -> 00, op_out = ex_rf_val.
- EX stall across retire: MEM/WB hit 0xBEEF with ex_advance=0, then next cycle mwb_wr=0 -> fwd_sel=11, op_out=0xBEEF. Then ex_advance=1 -> next cycle hold cleared and fwd_sel=00.
- Load-use, LOAD_STALL=1: idex_load=1, idex_rd=2, id_src[0]=2 used -> stall_id=1 for exactly 1 cycle. Next cycle the load is in MEM/WB and forwards with sel 01.
- Load-use, LOAD_STALL=3, with ex_advance=0 inserted in cycle 2 -> stall_id high for 4 cycles total, then FSM returns to RUN.
- Reset asserted mid-STALL and mid-hold -> stall_id and hold clear asynchronously, and fwd_sel returns to 00 with no live hit.
